// File: rtl/blink_mapper.sv
// Blink memory/IO mapper: segment registers, CPU-to-physical address translation,
// region chip selects, per-region wait states and IO register readback.
module blink_mapper #(
  parameter int unsigned CPU_AW = 16,
  parameter int unsigned NSEG = 4,
  parameter int unsigned BANK_W = 8,
  parameter logic [7:0] IO_COM = 8'hB0,
  parameter logic [7:0] IO_SR = 8'hD0,
  parameter logic [BANK_W-1:0] RAMS_BANK = BANK_W'(8'h10),
  parameter int unsigned ROM_WS = 1,
  parameter int unsigned RAM_WS = 0,
  parameter int unsigned EXT_WS = 2,
  localparam int unsigned SEG_W = $clog2(NSEG),
  localparam int unsigned SEG_AW = CPU_AW - SEG_W,
  localparam int unsigned PA_W = BANK_W + SEG_AW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CPU_AW-1:0] cpu_a,
  input  logic [7:0]        cpu_do,
  output logic [7:0]        cpu_di,
  input  logic              cpu_mreq_n,
  input  logic              cpu_iorq_n,
  input  logic              cpu_rd_n,
  input  logic              cpu_wr_n,
  input  logic              cpu_m1_n,
  input  logic              cpu_rfsh_n,
  output logic              cpu_wait_n,
  output logic [PA_W-1:0]   mem_a,
  output logic              rom_ce_n,
  output logic              ram_ce_n,
  output logic              ext_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  input  logic [7:0]        rom_di,
  input  logic [7:0]        ram_di,
  input  logic [7:0]        ext_di
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  logic [7:0]        com;
  logic [BANK_W-1:0] sr [NSEG];
  logic              mreq_q;
  logic              io_wr_q;
  state_t            state, state_d;
  logic [3:0]        cnt, cnt_d;
  logic              wait_n_d;

  logic [SEG_W-1:0]  seg;
  logic [BANK_W-1:0] bank;
  logic [2:0]        region;
  logic [3:0]        ws;
  logic              mem_act;
  logic              io_wr;
  logic              io_rd;
  logic              start;
  logic [7:0]        port;
  logic [7:0]        io_data;

  assign seg     = cpu_a[CPU_AW-1 -: SEG_W];
  assign port    = cpu_a[7:0];
  assign io_wr   = !cpu_iorq_n && !cpu_wr_n && cpu_m1_n;
  assign io_rd   = !cpu_iorq_n && !cpu_rd_n && cpu_m1_n;
  assign mem_act = !cpu_mreq_n && cpu_rfsh_n;
  assign start   = !cpu_mreq_n && mreq_q && cpu_rfsh_n;

  // Segment 0 lower half maps to bank 0 or the RAMS bank; offset bits pass straight through
  always_comb begin
    bank = sr[seg];
    if (seg == '0 && !cpu_a[SEG_AW-1])
      bank = com[2] ? RAMS_BANK : '0;
  end

  assign region = bank[BANK_W-1 -: 3];
  assign mem_a  = {bank, cpu_a[SEG_AW-1:0]};

  always_comb begin
    case (region)
      3'd0:    ws = 4'(ROM_WS);
      3'd1:    ws = 4'(RAM_WS);
      default: ws = 4'(EXT_WS);
    endcase
  end

  assign rom_ce_n = !(mem_act && region == 3'd0);
  assign ram_ce_n = !(mem_act && region == 3'd1);
  assign ext_ce_n = !(mem_act && region >= 3'd2);
  assign mem_oe_n = !(!cpu_mreq_n && !cpu_rd_n);
  assign mem_we_n = !(!cpu_mreq_n && !cpu_wr_n);

  always_comb begin
    io_data = 8'hFF;
    if (port == IO_COM)
      io_data = com;
    for (int k = 0; k < NSEG; k++)
      if (port == 8'(int'(IO_SR) + k))
        io_data = 8'(sr[k]);
  end

  always_comb begin
    cpu_di = 8'hFF;
    if (io_rd)
      cpu_di = io_data;
    else if (!cpu_mreq_n && !cpu_rd_n) begin
      case (region)
        3'd0:    cpu_di = rom_di;
        3'd1:    cpu_di = ram_di;
        default: cpu_di = ext_di;
      endcase
    end
  end

  // Registers are written once per IO write strobe, on its first sampled edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      com     <= '0;
      io_wr_q <= 1'b1;
      for (int k = 0; k < NSEG; k++)
        sr[k] <= '0;
    end else begin
      io_wr_q <= !io_wr;
      if (io_wr && io_wr_q) begin
        if (port == IO_COM)
          com <= cpu_do;
        for (int k = 0; k < NSEG; k++)
          if (port == 8'(int'(IO_SR) + k))
            sr[k] <= BANK_W'(cpu_do);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      mreq_q     <= 1'b1;
      cpu_wait_n <= 1'b1;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      mreq_q     <= cpu_mreq_n;
      cpu_wait_n <= wait_n_d;
    end
  end

  // Wait count is loaded at the start of the cycle, so later SR writes cannot change it
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (ws != 4'd0) begin
            state_d = S_WAIT;
            cnt_d   = ws - 4'd1;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_WAIT: begin
        if (cpu_mreq_n)
          state_d = S_IDLE;
        else if (cnt == 4'd0)
          state_d = S_HOLD;
        else
          cnt_d = cnt - 4'd1;
      end
      S_HOLD: begin
        if (cpu_mreq_n)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wait_n_d = (state_d != S_WAIT);
  end

endmodule

// File: tb/tb_blink_mapper.sv
// Directed bench for blink_mapper: translation/select table plus multi-cycle
// wait-state, held-write and reset sequences.
module tb_blink_mapper;

  logic        clk;
  logic        reset_n;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do;
  logic [7:0]  cpu_di;
  logic        cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cpu_rfsh_n;
  logic        cpu_wait_n;
  logic [21:0] mem_a;
  logic        rom_ce_n, ram_ce_n, ext_ce_n, mem_oe_n, mem_we_n;
  logic [7:0]  rom_di, ram_di, ext_di;

  int n_cmp = 0;
  int n_err = 0;

  blink_mapper dut (
    .clk(clk), .reset_n(reset_n), .cpu_a(cpu_a), .cpu_do(cpu_do), .cpu_di(cpu_di),
    .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n), .cpu_rd_n(cpu_rd_n),
    .cpu_wr_n(cpu_wr_n), .cpu_m1_n(cpu_m1_n), .cpu_rfsh_n(cpu_rfsh_n),
    .cpu_wait_n(cpu_wait_n), .mem_a(mem_a), .rom_ce_n(rom_ce_n), .ram_ce_n(ram_ce_n),
    .ext_ce_n(ext_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .rom_di(rom_di), .ram_di(ram_di), .ext_di(ext_di)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
    logic [21:0] ma;
    logic [4:0]  sel;   // {rom_ce_n, ram_ce_n, ext_ce_n, mem_oe_n, mem_we_n}
    logic [7:0]  di;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bus_idle();
    cpu_mreq_n = 1'b1; cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1;
    cpu_wr_n = 1'b1; cpu_m1_n = 1'b1; cpu_rfsh_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [7:0] p, input logic [7:0] d);
    cpu_a = {8'h00, p}; cpu_do = d; cpu_iorq_n = 1'b0; cpu_wr_n = 1'b0;
    step();
    bus_idle();
    step();
  endtask

  task automatic io_read(input logic [7:0] p, input logic [7:0] exp, input string nm);
    cpu_a = {8'h00, p}; cpu_iorq_n = 1'b0; cpu_rd_n = 1'b0;
    #1;
    check(nm, 32'(cpu_di), 32'(exp));
    bus_idle();
  endtask

  // Memory read: checks address/selects/data, then counts wait_n-low cycles over a fixed window
  task automatic mem_read(input logic [15:0] addr, input logic [21:0] ma, input logic [2:0] ce,
                          input logic [7:0] di, input int ws, input string nm);
    int lows;
    cpu_a = addr; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    #1;
    check({nm, "_mem_a"}, 32'(mem_a), 32'(ma));
    check({nm, "_ce"}, 32'({rom_ce_n, ram_ce_n, ext_ce_n}), 32'(ce));
    check({nm, "_di"}, 32'(cpu_di), 32'(di));
    lows = 0;
    repeat (6) begin
      step();
      if (!cpu_wait_n) lows++;
    end
    check({nm, "_ws"}, 32'(lows), 32'(ws));
    bus_idle();
    step();
  endtask

  initial begin
    int lows;
    rom_di = 8'hA1; ram_di = 8'hB2; ext_di = 8'hC3;
    cpu_a = '0; cpu_do = '0;
    bus_idle();
    reset_n = 1'b0;

    vecs[0]  = '{16'h4123, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 22'h044123, 5'b01101, 8'hA1};
    vecs[1]  = '{16'h8005, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 22'h084005, 5'b10101, 8'hB2};
    vecs[2]  = '{16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 22'h103FFF, 5'b11001, 8'hC3};
    vecs[3]  = '{16'h1FFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 22'h041FFF, 5'b01101, 8'hA1};
    vecs[4]  = '{16'h2000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 22'h00E000, 5'b01101, 8'hA1};
    vecs[5]  = '{16'h00D3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 22'h0400D3, 5'b11111, 8'h40};
    vecs[6]  = '{16'h00B0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 22'h0400B0, 5'b11111, 8'h04};
    vecs[7]  = '{16'h007F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 22'h04007F, 5'b11111, 8'hFF};
    vecs[8]  = '{16'h00D0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 22'h0400D0, 5'b11111, 8'hFF};
    vecs[9]  = '{16'h8005, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 22'h084005, 5'b11111, 8'hFF};
    vecs[10] = '{16'hC001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 22'h100001, 5'b11010, 8'hFF};

    repeat (3) @(posedge clk);
    #1;
    check("rst_wait_n", 32'(cpu_wait_n), 32'd1);
    reset_n = 1'b1;
    step();

    // Reset state and ROM access with one wait state
    io_read(8'hB0, 8'h00, "rst_com");
    for (int k = 0; k < 4; k++) io_read(8'(8'hD0 + k), 8'h00, "rst_sr");
    mem_read(16'h0100, 22'h000100, 3'b011, 8'hA1, 1, "rom0100");

    // RAM region through SR2, no wait
    io_write(8'hD2, 8'h21);
    mem_read(16'h8005, 22'h084005, 3'b101, 8'hB2, 0, "ram8005");
    io_read(8'hD2, 8'h21, "sr2_rb");

    // EXT region through SR3, two wait states
    io_write(8'hD3, 8'h40);
    mem_read(16'hC000, 22'h100000, 3'b110, 8'hC3, 2, "extC000");

    // RAMS bank for segment-0 lower half, SR0 for upper half
    io_write(8'hB0, 8'h04);
    io_write(8'hD0, 8'h03);
    mem_read(16'h0010, 22'h040010, 3'b011, 8'hA1, 1, "rams0010");
    mem_read(16'h2010, 22'h00E010, 3'b011, 8'hA1, 1, "sr0_2010");
    io_read(8'hB0, 8'h04, "com_rb");

    // Held IO write: only the first edge of the strobe writes
    cpu_a = 16'h00D1; cpu_do = 8'h11; cpu_iorq_n = 1'b0; cpu_wr_n = 1'b0;
    step();
    cpu_do = 8'h22;
    step();
    step();
    bus_idle();
    step();
    io_read(8'hD1, 8'h11, "sr1_held");
    io_read(8'h55, 8'hFF, "io_miss");

    // Combinational translation/select table
    for (int i = 0; i < 11; i++) begin
      cpu_a = vecs[i].a;
      cpu_mreq_n = vecs[i].mreq_n; cpu_iorq_n = vecs[i].iorq_n;
      cpu_rd_n = vecs[i].rd_n; cpu_wr_n = vecs[i].wr_n;
      cpu_m1_n = vecs[i].m1_n; cpu_rfsh_n = vecs[i].rfsh_n;
      #1;
      check($sformatf("vec%0d_mem_a", i), 32'(mem_a), 32'(vecs[i].ma));
      check($sformatf("vec%0d_sel", i),
            32'({rom_ce_n, ram_ce_n, ext_ce_n, mem_oe_n, mem_we_n}), 32'(vecs[i].sel));
      check($sformatf("vec%0d_di", i), 32'(cpu_di), 32'(vecs[i].di));
      bus_idle();
      step();
    end

    // Refresh cycle: no selects, no wait states
    cpu_a = 16'hC000; cpu_mreq_n = 1'b0; cpu_rfsh_n = 1'b0; cpu_m1_n = 1'b0;
    #1;
    check("rfsh_ce", 32'({rom_ce_n, ram_ce_n, ext_ce_n}), 32'h7);
    lows = 0;
    repeat (4) begin
      step();
      if (!cpu_wait_n) lows++;
    end
    check("rfsh_ws", 32'(lows), 32'd0);
    bus_idle();
    step();

    // Async reset in the middle of an EXT wait
    cpu_a = 16'hC000; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    step();
    check("pre_rst_wait", 32'(cpu_wait_n), 32'd0);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_mid_wait", 32'(cpu_wait_n), 32'd1);
    bus_idle();
    step();
    reset_n = 1'b1;
    step();
    io_read(8'hD3, 8'h00, "post_rst_sr3");
    io_read(8'hD1, 8'h00, "post_rst_sr1");
    io_read(8'hB0, 8'h00, "post_rst_com");
    mem_read(16'hC000, 22'h000000, 3'b011, 8'hA1, 1, "post_rst_C000");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
